motion_queue_sequencer: RTL and testbench

Buffers G-code move commands from the command decoder in a FIFO and feeds them one at a time into the motion pipeline (`jerk_acc_speed`). The sequencer owns the `start_driving_main`/`finish` handshake: it presents one move, holds it until the pipeline reports completion, then releases the handshake and issues the next move. On an endstop or filament error it halts, flushes the queue and latches a sticky fault until software clears it.

---
 rtl/motion_pkg.sv | 29 ++
 rtl/move_fifo.sv | 65 ++++++
 rtl/motion_queue_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_motion_queue_sequencer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared types for the motion queue sequencer
// Purpose: move command layout, sequencer state encoding and axis count.
// Axis index order everywhere: 0 = x, 1 = y, 2 = z, 3 = e0, 4 = e1.
package motion_pkg;

    localparam int AXES = 5;

    typedef logic signed [31:0] steps_t;

    typedef struct packed {
        logic [AXES-1:0][31:0] speed;   // microsteps/s, unsigned
        steps_t [AXES-1:0]     num;     // signed step counts
    } move_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RELEASE,
        ST_HALT
    } seq_state_t;

    // Steps actually travelled by an interrupted move: the executed count is
    // unsigned, so its direction comes from the sign of the planned count.
    function automatic steps_t partial_steps(input steps_t planned, input logic [31:0] done);
        return planned[31] ? -$signed(done) : $signed(done);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// rtl/move_fifo.sv - synchronous FIFO of move commands
// Purpose: DEPTH-entry queue (DEPTH a power of two) with flush.
// Ports: clk, reset (sync, active-high); push_i/data_i write; pop_i read
//        (data_o shows the head); flush_i empties the queue and discards a
//        same-cycle push; count_o/full_o/empty_o report occupancy.
module move_fifo
    import motion_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  move_cmd_t data_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output move_cmd_t data_o,
    output logic [AW:0] count_o,
    output logic      full_o,
    output logic      empty_o
);

    move_cmd_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/motion_queue_sequencer.sv
// rtl/motion_queue_sequencer.sv - queues G-code moves and hands them to the motion pipeline
// Purpose: FIFO-buffered moves, start_driving_main/finish handshake, fault halt.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready + cmd_speed_*/cmd_num_*
//        move input; abort, clear_error control; speed_*_main/num_*_m and
//        start_driving_main to the pipeline; finish, error, num_*_now from it;
//        busy, halted, count, moves_done status.
// Option MOTION_QUEUE_POSITION_EN: adds pos_* absolute position outputs and
//        the pos_load/pos_load_* preset inputs.
module motion_queue_sequencer
    import motion_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [31:0]        cmd_speed_x,
    input  logic [31:0]        cmd_speed_y,
    input  logic [31:0]        cmd_speed_z,
    input  logic [31:0]        cmd_speed_e0,
    input  logic [31:0]        cmd_speed_e1,
    input  logic signed [31:0] cmd_num_x,
    input  logic signed [31:0] cmd_num_y,
    input  logic signed [31:0] cmd_num_z,
    input  logic signed [31:0] cmd_num_e0,
    input  logic signed [31:0] cmd_num_e1,
    input  logic               abort,
    input  logic               clear_error,
    output logic [31:0]        speed_x_main,
    output logic [31:0]        speed_y_main,
    output logic [31:0]        speed_z_main,
    output logic [31:0]        speed_e0_main,
    output logic [31:0]        speed_e1_main,
    output logic signed [31:0] num_x_m,
    output logic signed [31:0] num_y_m,
    output logic signed [31:0] num_z_m,
    output logic signed [31:0] num_e0_m,
    output logic signed [31:0] num_e1_m,
    output logic               start_driving_main,
    input  logic               finish,
    input  logic               error,
    input  logic [31:0]        num_x_now,
    input  logic [31:0]        num_y_now,
    input  logic [31:0]        num_z_now,
    input  logic [31:0]        num_e0_now,
    input  logic [31:0]        num_e1_now,
`ifdef MOTION_QUEUE_POSITION_EN
    output logic signed [31:0] pos_x,
    output logic signed [31:0] pos_y,
    output logic signed [31:0] pos_z,
    output logic signed [31:0] pos_e0,
    output logic signed [31:0] pos_e1,
    input  logic               pos_load,
    input  logic signed [31:0] pos_load_x,
    input  logic signed [31:0] pos_load_y,
    input  logic signed [31:0] pos_load_z,
    input  logic signed [31:0] pos_load_e0,
    input  logic signed [31:0] pos_load_e1,
`endif
    output logic               busy,
    output logic               halted,
    output logic [AW:0]        count,
    output logic [31:0]        moves_done
);

    seq_state_t            state_q;
    seq_state_t            state_d;
    move_cmd_t             cmd_in;
    move_cmd_t             head;
    move_cmd_t             move_q;
    logic [31:0]           moves_done_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_flush;
    logic                  abort_act;
    logic [AXES-1:0][31:0] now_vec;

    assign cmd_in.speed = {cmd_speed_e1, cmd_speed_e0, cmd_speed_z, cmd_speed_y, cmd_speed_x};
    assign cmd_in.num   = {cmd_num_e1, cmd_num_e0, cmd_num_z, cmd_num_y, cmd_num_x};
    assign now_vec      = {num_e1_now, num_e0_now, num_z_now, num_y_now, num_x_now};

    // HALT already empties the queue and refuses input, so abort means nothing there.
    assign abort_act  = abort && (state_q != ST_HALT);
    assign cmd_ready  = !fifo_full && (state_q != ST_HALT);
    assign fifo_push  = cmd_valid && cmd_ready && !abort_act;
    assign fifo_flush = abort_act || (state_d == ST_HALT);

    move_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (cmd_in),
        .pop_i   (state_q == ST_LOAD),
        .flush_i (fifo_flush),
        .data_o  (head),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_RUN;
            ST_RUN:     if (finish) state_d = error ? ST_HALT : ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            ST_HALT:    if (clear_error) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (abort_act) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        start_driving_main = (state_q == ST_RUN);
        halted             = (state_q == ST_HALT);
        busy               = (state_q != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            move_q <= '0;
        end else if ((state_q == ST_LOAD) && !abort_act) begin
            move_q <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            moves_done_q <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_RELEASE)) begin
            moves_done_q <= moves_done_q + 1'b1;
        end
    end

    assign moves_done    = moves_done_q;
    assign speed_x_main  = move_q.speed[0];
    assign speed_y_main  = move_q.speed[1];
    assign speed_z_main  = move_q.speed[2];
    assign speed_e0_main = move_q.speed[3];
    assign speed_e1_main = move_q.speed[4];
    assign num_x_m       = move_q.num[0];
    assign num_y_m       = move_q.num[1];
    assign num_z_m       = move_q.num[2];
    assign num_e0_m      = move_q.num[3];
    assign num_e1_m      = move_q.num[4];

`ifdef MOTION_QUEUE_POSITION_EN
    steps_t [AXES-1:0] pos_q;
    steps_t [AXES-1:0] pos_load_vec;

    assign pos_load_vec = {pos_load_e1, pos_load_e0, pos_load_z, pos_load_y, pos_load_x};

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= '0;
        end else if (pos_load && ((state_q == ST_IDLE) || (state_q == ST_HALT))) begin
            pos_q <= pos_load_vec;
        end else if (state_q == ST_RELEASE) begin
            for (int a = 0; a < AXES; a++) begin
                pos_q[a] <= pos_q[a] + move_q.num[a];
            end
        end else if ((state_q == ST_RUN) && ((state_d == ST_HALT) || abort_act)) begin
            // Interrupted move: account only for the steps already executed.
            for (int a = 0; a < AXES; a++) begin
                pos_q[a] <= pos_q[a] + partial_steps(move_q.num[a], now_vec[a]);
            end
        end
    end

    assign pos_x  = pos_q[0];
    assign pos_y  = pos_q[1];
    assign pos_z  = pos_q[2];
    assign pos_e0 = pos_q[3];
    assign pos_e1 = pos_q[4];
`else
    logic unused_now;
    assign unused_now = ^now_vec;
`endif

endmodule

// File: tb/tb_motion_queue_sequencer.sv
// tb/tb_motion_queue_sequencer.sv - randomized self-checking bench for motion_queue_sequencer
module tb_motion_queue_sequencer;

    typedef struct {
        logic [31:0] spd [5];
        logic [31:0] num [5];
    } mv_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_speed [5];
    logic [31:0] cmd_num [5];
    logic        abort;
    logic        clear_error;
    logic [31:0] speed_main [5];
    logic [31:0] num_m [5];
    logic        start;
    logic        finish;
    logic        error;
    logic [31:0] now [5];
    logic        busy;
    logic        halted;
    logic [3:0]  count;
    logic [31:0] moves_done;
`ifdef MOTION_QUEUE_POSITION_EN
    logic [31:0] pos [5];
    logic        pos_load;
    logic [31:0] pos_ld [5];
`endif

    mv_t         mq[$];
    logic [31:0] md_exp;
    int          pos_exp [5];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    motion_queue_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed_x(cmd_speed[0]), .cmd_speed_y(cmd_speed[1]), .cmd_speed_z(cmd_speed[2]),
        .cmd_speed_e0(cmd_speed[3]), .cmd_speed_e1(cmd_speed[4]),
        .cmd_num_x(cmd_num[0]), .cmd_num_y(cmd_num[1]), .cmd_num_z(cmd_num[2]),
        .cmd_num_e0(cmd_num[3]), .cmd_num_e1(cmd_num[4]),
        .abort(abort), .clear_error(clear_error),
        .speed_x_main(speed_main[0]), .speed_y_main(speed_main[1]), .speed_z_main(speed_main[2]),
        .speed_e0_main(speed_main[3]), .speed_e1_main(speed_main[4]),
        .num_x_m(num_m[0]), .num_y_m(num_m[1]), .num_z_m(num_m[2]),
        .num_e0_m(num_m[3]), .num_e1_m(num_m[4]),
        .start_driving_main(start), .finish(finish), .error(error),
        .num_x_now(now[0]), .num_y_now(now[1]), .num_z_now(now[2]),
        .num_e0_now(now[3]), .num_e1_now(now[4]),
`ifdef MOTION_QUEUE_POSITION_EN
        .pos_x(pos[0]), .pos_y(pos[1]), .pos_z(pos[2]), .pos_e0(pos[3]), .pos_e1(pos[4]),
        .pos_load(pos_load),
        .pos_load_x(pos_ld[0]), .pos_load_y(pos_ld[1]), .pos_load_z(pos_ld[2]),
        .pos_load_e0(pos_ld[3]), .pos_load_e1(pos_ld[4]),
`endif
        .busy(busy), .halted(halted), .count(count), .moves_done(moves_done)
    );

    function automatic mv_t rand_move();
        mv_t m;
        for (int a = 0; a < 5; a++) begin
            m.spd[a] = $urandom;
            m.num[a] = 32'(int'($urandom_range(0, 20000)) - 10000);
        end
        return m;
    endfunction

    function automatic int partial(input logic [31:0] planned, input logic [31:0] done);
        return planned[31] ? -int'(done) : int'(done);
    endfunction

    task automatic drive_cmd(input mv_t m);
        for (int a = 0; a < 5; a++) begin
            cmd_speed[a] = m.spd[a];
            cmd_num[a]   = m.num[a];
        end
    endtask

    task automatic model_clear();
        mq.delete();
        md_exp = 0;
        for (int a = 0; a < 5; a++) pos_exp[a] = 0;
    endtask

    // Offers one move for exactly one clock; the model queues it only if it was accepted.
    task automatic push_move(input mv_t m);
        drive_cmd(m);
        cmd_valid = 1'b1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL push_ready: cmd_ready=%b required 1", cmd_ready);
        end else begin
            mq.push_back(m);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (start !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_vec++;
        if (start !== 1'b1) begin
            n_err++;
            $display("FAIL start_timeout: start_driving_main=%b required 1", start);
        end
    endtask

    // Waits for the running move, compares it with the model head, holds it a
    // random time, then completes it and checks the release.
    task automatic service_move();
        int  lat;
        mv_t m;
        wait_start(lat);
        n_vec++;
        if (mq.size() == 0) begin
            n_err++;
            $display("FAIL model_empty: size=%0d required >0", mq.size());
            return;
        end
        m = mq.pop_front();
        for (int a = 0; a < 5; a++) begin
            n_vec++;
            if (speed_main[a] !== m.spd[a] || num_m[a] !== m.num[a]) begin
                n_err++;
                $display("FAIL move_axis%0d: speed=%h num=%h required speed=%h num=%h",
                         a, speed_main[a], num_m[a], m.spd[a], m.num[a]);
            end
        end
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            n_vec++;
            if (start !== 1'b1) begin
                n_err++;
                $display("FAIL hold_start: start=%b required 1", start);
            end
        end
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        md_exp = md_exp + 1;
        for (int a = 0; a < 5; a++) pos_exp[a] += int'(m.num[a]);
        n_vec++;
        if (start !== 1'b0 || moves_done !== md_exp) begin
            n_err++;
            $display("FAIL release: start=%b moves_done=%0d required start=0 moves_done=%0d",
                     start, moves_done, md_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 0; abort = 0; clear_error = 0; finish = 0; error = 0;
        for (int a = 0; a < 5; a++) begin
            cmd_speed[a] = 0; cmd_num[a] = 0; now[a] = 0;
        end
`ifdef MOTION_QUEUE_POSITION_EN
        pos_load = 0;
        for (int a = 0; a < 5; a++) pos_ld[a] = 0;
`endif
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if (start !== 0 || halted !== 0 || count !== 0 || moves_done !== 0 || busy !== 0 || cmd_ready !== 1) begin
            n_err++;
            $display("FAIL reset_status: start=%b halted=%b count=%0d moves_done=%0d busy=%b ready=%b required 0 0 0 0 0 1",
                     start, halted, count, moves_done, busy, cmd_ready);
        end
        for (int a = 0; a < 5; a++) begin
            n_vec++;
            if (speed_main[a] !== 0 || num_m[a] !== 0) begin
                n_err++;
                $display("FAIL reset_axis%0d: speed=%h num=%h required 0 0", a, speed_main[a], num_m[a]);
            end
        end
    endtask

    task automatic test_single();
        mv_t m;
        int  lat;
        m = rand_move();
        m.num[0] = 1000;
        m.spd[0] = 2000;
        push_move(m);
        wait_start(lat);
        n_vec++;
        if (lat + 1 != 3 || num_m[0] !== 32'd1000) begin
            n_err++;
            $display("FAIL first_latency: cycles=%0d num_x_m=%0d required 3 1000", lat + 1, num_m[0]);
        end
        service_move();
        n_vec++;
        if (moves_done !== 32'd1) begin
            n_err++;
            $display("FAIL single_done: moves_done=%0d required 1", moves_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        repeat (3) push_move(rand_move());
        service_move();
        repeat (2) begin
            wait_start(lat);
            n_vec++;
            if (lat != 3) begin
                n_err++;
                $display("FAIL gap_cycles: low=%0d required 3", lat);
            end
            service_move();
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_fill();
        mv_t m10;
        mv_t m;
        for (int i = 0; i < 8; i++) push_move(rand_move());
        n_vec++;
        if (count !== 4'd7) begin
            n_err++;
            $display("FAIL fill_count7: count=%0d required 7", count);
        end
        push_move(rand_move());
        n_vec++;
        if (count !== 4'd8 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: count=%0d ready=%b required 8 0", count, cmd_ready);
        end
        m10 = rand_move();
        drive_cmd(m10);
        cmd_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (cmd_ready !== 1'b0 || count !== 4'd8) begin
                n_err++;
                $display("FAIL full_hold: ready=%b count=%0d required 0 8", cmd_ready, count);
            end
        end
        m = mq.pop_front();
        n_vec++;
        if (start !== 1'b1 || num_m[0] !== m.num[0]) begin
            n_err++;
            $display("FAIL fill_head: start=%b num_x=%h required 1 %h", start, num_m[0], m.num[0]);
        end
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        md_exp = md_exp + 1;
        for (int a = 0; a < 5; a++) pos_exp[a] += int'(m.num[a]);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (cmd_ready !== 1'b0) begin
                n_err++;
                $display("FAIL ready_before_pop%0d: ready=%b required 0", k, cmd_ready);
            end
            @(negedge clk);
        end
        n_vec++;
        if (cmd_ready !== 1'b1 || count !== 4'd7) begin
            n_err++;
            $display("FAIL ready_after_pop: ready=%b count=%0d required 1 7", cmd_ready, count);
        end
        mq.push_back(m10);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_vec++;
        if (count !== 4'd8) begin
            n_err++;
            $display("FAIL tenth_push: count=%0d required 8", count);
        end
        while (mq.size() > 0) service_move();
    endtask

    task automatic test_error_halt();
        int  lat;
        mv_t m;
        @(negedge clk);
        repeat (4) push_move(rand_move());
        wait_start(lat);
        n_vec++;
        if (count !== 4'd3) begin
            n_err++;
            $display("FAIL halt_queued: count=%0d required 3", count);
        end
        for (int a = 0; a < 5; a++) now[a] = $urandom_range(0, 3000);
        m = mq.pop_front();
        finish = 1'b1; error = 1'b1;
        @(negedge clk);
        finish = 1'b0; error = 1'b0;
        for (int a = 0; a < 5; a++) pos_exp[a] += partial(m.num[a], now[a]);
        mq.delete();
        n_vec++;
        if (halted !== 1 || count !== 0 || cmd_ready !== 0 || start !== 0 || moves_done !== md_exp) begin
            n_err++;
            $display("FAIL halt_entry: halted=%b count=%0d ready=%b start=%b done=%0d required 1 0 0 0 %0d",
                     halted, count, cmd_ready, start, moves_done, md_exp);
        end
        abort = 1'b1; finish = 1'b1;
        @(negedge clk);
        abort = 1'b0; finish = 1'b0;
        n_vec++;
        if (halted !== 1'b1) begin
            n_err++;
            $display("FAIL halt_abort_ignored: halted=%b required 1", halted);
        end
`ifdef MOTION_QUEUE_POSITION_EN
        for (int a = 0; a < 5; a++) begin
            n_vec++;
            if (pos[a] !== 32'(pos_exp[a])) begin
                n_err++;
                $display("FAIL halt_pos%0d: pos=%0d required %0d", a, $signed(pos[a]), pos_exp[a]);
            end
        end
`endif
        clear_error = 1'b1; abort = 1'b1;
        @(negedge clk);
        clear_error = 1'b0; abort = 1'b0;
        n_vec++;
        if (halted !== 0 || cmd_ready !== 1 || count !== 0 || busy !== 0) begin
            n_err++;
            $display("FAIL halt_clear: halted=%b ready=%b count=%0d busy=%b required 0 1 0 0",
                     halted, cmd_ready, count, busy);
        end
    endtask

    task automatic test_abort();
        int  lat;
        mv_t m;
        m = rand_move();
        m.num[0] = 32'hFFFF_FC18;
        push_move(m);
        push_move(rand_move());
        wait_start(lat);
        n_vec++;
        if (num_m[0] !== 32'hFFFF_FC18) begin
            n_err++;
            $display("FAIL abort_num: num_x_m=%h required fffffc18", num_m[0]);
        end
        for (int a = 0; a < 5; a++) now[a] = $urandom_range(0, 900);
        now[0] = 400;
        abort = 1'b1;
        drive_cmd(rand_move());
        cmd_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; cmd_valid = 1'b0;
        for (int a = 0; a < 5; a++) pos_exp[a] += partial(m.num[a], now[a]);
        mq.delete();
        n_vec++;
        if (start !== 0 || count !== 0 || moves_done !== md_exp) begin
            n_err++;
            $display("FAIL abort_run: start=%b count=%0d done=%0d required 0 0 %0d",
                     start, count, moves_done, md_exp);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if (start !== 0 || count !== 0 || busy !== 0) begin
            n_err++;
            $display("FAIL abort_push_dropped: start=%b count=%0d busy=%b required 0 0 0", start, count, busy);
        end
`ifdef MOTION_QUEUE_POSITION_EN
        for (int a = 0; a < 5; a++) begin
            n_vec++;
            if (pos[a] !== 32'(pos_exp[a])) begin
                n_err++;
                $display("FAIL abort_pos%0d: pos=%0d required %0d", a, $signed(pos[a]), pos_exp[a]);
            end
        end
`endif
    endtask

`ifdef MOTION_QUEUE_POSITION_EN
    task automatic test_position();
        mv_t m;
        pos_load = 1'b1;
        for (int a = 0; a < 5; a++) pos_ld[a] = 0;
        @(negedge clk);
        pos_load = 1'b0;
        for (int a = 0; a < 5; a++) pos_exp[a] = 0;
        m = rand_move(); m.num[0] = 500;
        push_move(m);
        m = rand_move(); m.num[0] = 32'hFFFF_FF38;
        push_move(m);
        service_move();
        service_move();
        @(negedge clk);
        n_vec++;
        if (pos[0] !== 32'd300) begin
            n_err++;
            $display("FAIL pos_x_sum: pos_x=%0d required 300", $signed(pos[0]));
        end
        for (int a = 1; a < 5; a++) begin
            n_vec++;
            if (pos[a] !== 32'(pos_exp[a])) begin
                n_err++;
                $display("FAIL pos_sum%0d: pos=%0d required %0d", a, $signed(pos[a]), pos_exp[a]);
            end
        end
        pos_load = 1'b1;
        for (int a = 0; a < 5; a++) pos_ld[a] = $urandom;
        pos_ld[0] = 0;
        @(negedge clk);
        pos_load = 1'b0;
        for (int a = 0; a < 5; a++) begin
            pos_exp[a] = int'(pos_ld[a]);
            n_vec++;
            if (pos[a] !== pos_ld[a]) begin
                n_err++;
                $display("FAIL pos_load%0d: pos=%h required %h", a, pos[a], pos_ld[a]);
            end
        end
    endtask
`endif

    task automatic test_reset_midmove();
        int lat;
        push_move(rand_move());
        wait_start(lat);
        reset = 1'b1;
        @(negedge clk);
        model_clear();
        n_vec++;
        if (start !== 0 || count !== 0 || moves_done !== 0 || halted !== 0 || busy !== 0 || cmd_ready !== 1) begin
            n_err++;
            $display("FAIL midmove_reset: start=%b count=%0d done=%0d halted=%b busy=%b ready=%b required 0 0 0 0 0 1",
                     start, count, moves_done, halted, busy, cmd_ready);
        end
        for (int a = 0; a < 5; a++) begin
            n_vec++;
            if (speed_main[a] !== 0 || num_m[a] !== 0) begin
                n_err++;
                $display("FAIL midmove_axis%0d: speed=%h num=%h required 0 0", a, speed_main[a], num_m[a]);
            end
`ifdef MOTION_QUEUE_POSITION_EN
            n_vec++;
            if (pos[a] !== 0) begin
                n_err++;
                $display("FAIL midmove_pos%0d: pos=%h required 0", a, pos[a]);
            end
`endif
        end
        reset = 1'b0;
        push_move(rand_move());
        wait_start(lat);
        n_vec++;
        if (lat + 1 != 3) begin
            n_err++;
            $display("FAIL post_reset_latency: cycles=%0d required 3", lat + 1);
        end
        service_move();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_error_halt();
        test_abort();
`ifdef MOTION_QUEUE_POSITION_EN
        test_position();
`endif
        test_reset_midmove();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
